// File: rtl/psum_pkg.sv
// Shared types and helpers for the partial-sum line buffer.
package psum_pkg;

    localparam int unsigned PSUM_BIN_LEN       = 16;
    localparam int unsigned PSUM_KERNEL_HEIGHT = 3;

    // One partial sum and one channel's vector of kernel-row slots.
    typedef logic [PSUM_BIN_LEN-1:0] psum_t;
    typedef psum_t [PSUM_KERNEL_HEIGHT-1:0] psum_slots_t;

    // Width able to hold the values 0..n-1; never narrower than one bit.
    function automatic int unsigned col_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/psum_channel_mem.sv
// One channel's (KERNEL_HEIGHT-1) x INPUT_WIDTH partial-sum storage.
// Combinational read, registered write, not reset.
// PRB_ACCUM_EN: when defined, accum_i selects a saturating read-modify-write store.
module psum_channel_mem
    import psum_pkg::*;
#(
    parameter int unsigned BIN_LEN       = PSUM_BIN_LEN,
    parameter int unsigned KERNEL_HEIGHT = PSUM_KERNEL_HEIGHT,
    parameter int unsigned INPUT_WIDTH   = 32,
    parameter int unsigned COL_W         = col_w(INPUT_WIDTH)
) (
    input  logic                                   clk,
    input  logic [COL_W-1:0]                       rd_addr_i,
    output logic [KERNEL_HEIGHT-2:0][BIN_LEN-1:0]  rd_data_c_o,
    input  logic                                   wr_en_i,
    input  logic [COL_W-1:0]                       wr_addr_i,
    input  logic [KERNEL_HEIGHT-2:0][BIN_LEN-1:0]  wr_data_i,
    input  logic                                   accum_i
);

    logic [BIN_LEN-1:0] mem_q [KERNEL_HEIGHT-1][INPUT_WIDTH];
    logic [KERNEL_HEIGHT-2:0][BIN_LEN-1:0] wr_val_c;

    // Asynchronous read of every slot at the fetch column.
    always_comb begin
        rd_data_c_o = '0;
        for (int s = 0; s < int'(KERNEL_HEIGHT) - 1; s++) begin
            rd_data_c_o[s] = mem_q[s][rd_addr_i];
        end
    end

`ifdef PRB_ACCUM_EN
    logic [KERNEL_HEIGHT-2:0][BIN_LEN:0] sum_c;

    // Store value: overwrite, or unsigned add saturating at all-ones.
    always_comb begin
        sum_c    = '0;
        wr_val_c = wr_data_i;
        for (int s = 0; s < int'(KERNEL_HEIGHT) - 1; s++) begin
            sum_c[s] = {1'b0, mem_q[s][wr_addr_i]} + {1'b0, wr_data_i[s]};
            if (accum_i) begin
                wr_val_c[s] = sum_c[s][BIN_LEN] ? '1 : sum_c[s][BIN_LEN-1:0];
            end
        end
    end
`else
    logic unused_accum;

    // Store value is always a plain overwrite.
    always_comb begin
        wr_val_c     = wr_data_i;
        unused_accum = accum_i;
    end
`endif

    // Write port; storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int s = 0; s < int'(KERNEL_HEIGHT) - 1; s++) begin
                mem_q[s][wr_addr_i] <= wr_val_c[s];
            end
        end
    end

endmodule

// File: rtl/psum_line_buffer.sv
// Multi-channel partial-sum line buffer with internal column/row tracking,
// row gating of unfilled rows and a one-deep valid/ready output register.
// PRB_ACCUM_EN: when defined, accum_i = 1 makes stores saturating accumulates.
module psum_line_buffer
    import psum_pkg::*;
#(
    parameter  int unsigned BIN_LEN       = PSUM_BIN_LEN,
    parameter  int unsigned KERNEL_HEIGHT = PSUM_KERNEL_HEIGHT,
    parameter  int unsigned KERNEL_WIDTH  = 3,
    parameter  int unsigned INPUT_WIDTH   = 32,
    parameter  int unsigned CHANNELS      = 4,
    localparam int unsigned COL_W         = col_w(INPUT_WIDTH)
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 in_valid_i,
    output logic                                                 in_ready_o,
    input  logic                                                 frame_start_i,
    input  logic                                                 row_start_i,
    input  logic                                                 accum_i,
    input  logic [CHANNELS-1:0][KERNEL_HEIGHT-1:0][BIN_LEN-1:0]  store_vals_i,
    output logic                                                 out_valid_o,
    input  logic                                                 out_ready_i,
    output logic [CHANNELS-1:0][KERNEL_HEIGHT-1:0][BIN_LEN-1:0]  fetch_vals_o,
    output logic [COL_W-1:0]                                     out_col_o,
    output logic                                                 out_last_o
);

    localparam int unsigned      ROW_W    = col_w(KERNEL_HEIGHT);
    localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(KERNEL_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(INPUT_WIDTH - 1);
    localparam logic [COL_W-1:0] WR_OFS   = COL_W'(KERNEL_WIDTH - 1);

    typedef logic [CHANNELS-1:0][KERNEL_HEIGHT-1:0][BIN_LEN-1:0] fetch_t;

    logic [COL_W-1:0] col_q,       col_d;
    logic [ROW_W-1:0] rows_q,      rows_d;
    logic             out_valid_q, out_valid_d;
    fetch_t           fetch_q,     fetch_d;
    logic [COL_W-1:0] out_col_q,   out_col_d;
    logic             out_last_q,  out_last_d;

    logic             accept_c;
    logic [COL_W-1:0] ec_c;
    logic [ROW_W-1:0] rows_eff_c;
    logic [ROW_W-1:0] rows_next_c;
    logic             wr_en_c;
    logic [COL_W-1:0] wr_addr_c;
    fetch_t           fetch_c;

    logic [CHANNELS-1:0][KERNEL_HEIGHT-2:0][BIN_LEN-1:0] rd_data_c;
    logic [CHANNELS-1:0][BIN_LEN-1:0]                    unused_top_slot;

    assign in_ready_o = !out_valid_q || out_ready_i;
    assign accept_c   = in_valid_i && in_ready_o;

    // Effective column/row for this beat, honouring frame and early row starts.
    always_comb begin
        ec_c       = (frame_start_i || row_start_i) ? '0 : col_q;
        rows_eff_c = rows_q;
        if (frame_start_i) begin
            rows_eff_c = '0;
        end else if (row_start_i && (col_q != '0)) begin
            rows_eff_c = (rows_q < ROW_MAX) ? rows_q + ROW_W'(1) : ROW_MAX;
        end
        rows_next_c = (rows_eff_c < ROW_MAX) ? rows_eff_c + ROW_W'(1) : ROW_MAX;
        wr_en_c     = accept_c && (ec_c >= WR_OFS);
        wr_addr_c   = ec_c - WR_OFS;
    end

    // Per-channel storage; the top kernel-row slot is never stored.
    for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_chan
        psum_channel_mem #(
            .BIN_LEN       (BIN_LEN),
            .KERNEL_HEIGHT (KERNEL_HEIGHT),
            .INPUT_WIDTH   (INPUT_WIDTH),
            .COL_W         (COL_W)
        ) u_mem (
            .clk         (clk),
            .rd_addr_i   (ec_c),
            .rd_data_c_o (rd_data_c[c]),
            .wr_en_i     (wr_en_c),
            .wr_addr_i   (wr_addr_c),
            .wr_data_i   (store_vals_i[c][KERNEL_HEIGHT-2:0]),
            .accum_i     (accum_i)
        );
        assign unused_top_slot[c] = store_vals_i[c][KERNEL_HEIGHT-1];
    end

    // Slot 0 is always zero; slot i shows row i-1 only once that row is filled.
    always_comb begin
        fetch_c = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            for (int s = 1; s < int'(KERNEL_HEIGHT); s++) begin
                if (rows_eff_c >= ROW_W'(s)) begin
                    fetch_c[c][s] = rd_data_c[c][s-1];
                end
            end
        end
    end

    // Next state: counters advance and the output register loads on accept.
    always_comb begin
        col_d       = col_q;
        rows_d      = rows_q;
        out_valid_d = out_valid_q;
        fetch_d     = fetch_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;
        if (accept_c) begin
            out_valid_d = 1'b1;
            fetch_d     = fetch_c;
            out_col_d   = ec_c;
            out_last_d  = (ec_c == COL_LAST);
            if (ec_c == COL_LAST) begin
                col_d  = '0;
                rows_d = rows_next_c;
            end else begin
                col_d  = ec_c + COL_W'(1);
                rows_d = rows_eff_c;
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            rows_q      <= '0;
            out_valid_q <= 1'b0;
            fetch_q     <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            rows_q      <= rows_d;
            out_valid_q <= out_valid_d;
            fetch_q     <= fetch_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign fetch_vals_o = fetch_q;
    assign out_col_o    = out_col_q;
    assign out_last_o   = out_last_q;

endmodule

// File: tb/tb_psum_line_buffer.sv
// Self-checking bench for psum_line_buffer against a behavioural line-buffer model.
module tb_psum_line_buffer;
    import psum_pkg::*;

    localparam int unsigned BIN  = 16;
    localparam int unsigned KH   = 3;
    localparam int unsigned KW   = 3;
    localparam int unsigned IW   = 32;
    localparam int unsigned CH   = 4;
    localparam int unsigned CW   = 5;
    localparam int unsigned MAXV = (1 << BIN) - 1;

    typedef logic [CH-1:0][KH-1:0][BIN-1:0] vec_t;

    logic          clk, rst_n, in_valid, in_ready, frame_start, row_start, accum;
    logic          out_valid, out_ready, out_last;
    vec_t          store_vals, fetch_vals;
    logic [CW-1:0] out_col;

    // Model state: stored sums, whether each entry was ever written, counters.
    int unsigned m_mem   [CH][KH-1][IW];
    bit          m_known [CH][KH-1][IW];
    int          m_col, m_rows, exp_col;
    bit          exp_last, exp_ov;
    vec_t        exp_fetch, exp_mask;
    int          n_cmp, n_bad;

    psum_line_buffer #(
        .BIN_LEN(BIN), .KERNEL_HEIGHT(KH), .KERNEL_WIDTH(KW),
        .INPUT_WIDTH(IW), .CHANNELS(CH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .frame_start_i(frame_start), .row_start_i(row_start), .accum_i(accum),
        .store_vals_i(store_vals),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .fetch_vals_o(fetch_vals), .out_col_o(out_col), .out_last_o(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one accepted beat to the model: fetch first, then store, then counters.
    task automatic model_step();
        int ec, re, a;
        int unsigned v, old;
        ec = (frame_start || row_start) ? 0 : m_col;
        if (frame_start) re = 0;
        else if (row_start && m_col != 0) re = (m_rows + 1 > int'(KH) - 1) ? int'(KH) - 1 : m_rows + 1;
        else re = m_rows;
        exp_fetch = '0;
        exp_mask  = '1;
        for (int c = 0; c < int'(CH); c++)
            for (int s = 1; s < int'(KH); s++)
                if (re >= s) begin
                    exp_fetch[c][s] = BIN'(m_mem[c][s-1][ec]);
                    if (!m_known[c][s-1][ec]) exp_mask[c][s] = '0;
                end
        if (ec >= int'(KW) - 1) begin
            a = ec - (int'(KW) - 1);
            for (int c = 0; c < int'(CH); c++)
                for (int s = 0; s < int'(KH) - 1; s++) begin
                    v   = 32'(store_vals[c][s]);
                    old = m_mem[c][s][a];
`ifdef PRB_ACCUM_EN
                    if (accum) begin
                        m_mem[c][s][a] = (old + v > MAXV) ? MAXV : old + v;
                    end else begin
                        m_mem[c][s][a]   = v;
                        m_known[c][s][a] = 1'b1;
                    end
`else
                    if (old == 0 || old != 0) m_mem[c][s][a] = v;
                    m_known[c][s][a] = 1'b1;
`endif
                end
        end
        if (ec == int'(IW) - 1) begin
            m_col  = 0;
            m_rows = (re + 1 > int'(KH) - 1) ? int'(KH) - 1 : re + 1;
        end else begin
            m_col  = ec + 1;
            m_rows = re;
        end
        exp_col  = ec;
        exp_last = (ec == int'(IW) - 1);
        exp_ov   = 1'b1;
    endtask

    task automatic rand_vals();
        for (int c = 0; c < int'(CH); c++)
            for (int s = 0; s < int'(KH); s++)
                store_vals[c][s] = BIN'($urandom);
    endtask

    // Drive one beat with out_ready high; returns at posedge+1 with the output visible.
    task automatic send_beat(input bit fs, input bit rs, input bit acc);
        frame_start = fs; row_start = rs; accum = acc;
        in_valid = 1'b1; out_ready = 1'b1;
        model_step();
        @(posedge clk); #1;
        in_valid = 1'b0; frame_start = 1'b0; row_start = 1'b0; accum = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        frame_start = 1'b0; row_start = 1'b0; accum = 1'b0; store_vals = '0;
        m_col = 0; m_rows = 0; exp_ov = 1'b0;
        for (int c = 0; c < int'(CH); c++)
            for (int s = 0; s < int'(KH) - 1; s++)
                for (int a = 0; a < int'(IW); a++) begin
                    m_mem[c][s][a] = 0; m_known[c][s][a] = 1'b0;
                end
        #12;
        n_cmp++;
        if (out_valid !== 1'b0 || fetch_vals !== '0 || out_col !== '0 || out_last !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values: valid=%b fetch=%h col=%0d last=%b, want 0/0/0/0",
                     out_valid, fetch_vals, out_col, out_last);
        end
        rst_n = 1'b1; #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        vec_t want;
        for (int b = 0; b < 96; b++) begin
            int k, r;
            k = b % 32; r = b / 32;
            for (int c = 0; c < int'(CH); c++)
                for (int s = 0; s < int'(KH); s++)
                    store_vals[c][s] = BIN'(100 * c + 10 * s + k);
            send_beat(b == 0, 1'b0, 1'b0);
            n_cmp++;
            if ((fetch_vals & exp_mask) !== (exp_fetch & exp_mask) || out_col !== CW'(exp_col)
                || out_last !== exp_last || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL fill_model b=%0d: fetch=%h col=%0d last=%b, want fetch=%h col=%0d last=%b",
                         b, fetch_vals, out_col, out_last, exp_fetch, exp_col, exp_last);
            end
            if (r == 0 || k <= 29) begin
                want = '0;
                for (int c = 0; c < int'(CH); c++) begin
                    if (r >= 1) want[c][1] = BIN'(100 * c + k + 2);
                    if (r >= 2) want[c][2] = BIN'(100 * c + 10 + k + 2);
                end
                n_cmp++;
                if (fetch_vals !== want) begin
                    n_bad++;
                    $display("FAIL fill_pattern row=%0d col=%0d: got %h want %h", r, k, fetch_vals, want);
                end
            end
        end
    endtask

    task automatic test_stall();
        vec_t hold_f, hold_m;
        int   hold_c;
        for (int b = 0; b < 10; b++) begin
            rand_vals(); send_beat(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if ((fetch_vals & exp_mask) !== (exp_fetch & exp_mask) || out_col !== CW'(exp_col)) begin
                n_bad++;
                $display("FAIL stall_pre b=%0d: fetch=%h col=%0d want %h col=%0d",
                         b, fetch_vals, out_col, exp_fetch, exp_col);
            end
        end
        hold_f = exp_fetch; hold_m = exp_mask; hold_c = exp_col;
        rand_vals(); in_valid = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_bad++; $display("FAIL stall_ready cyc=%0d: got %b want 0", k, in_ready);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || (fetch_vals & hold_m) !== (hold_f & hold_m) || out_col !== CW'(hold_c)) begin
                n_bad++;
                $display("FAIL stall_hold cyc=%0d: valid=%b fetch=%h col=%0d want 1 %h %0d",
                         k, out_valid, fetch_vals, out_col, hold_f, hold_c);
            end
        end
        out_ready = 1'b1;
        model_step();
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_col !== CW'(hold_c + 1) || (fetch_vals & exp_mask) !== (exp_fetch & exp_mask)) begin
            n_bad++;
            $display("FAIL stall_release: col=%0d fetch=%h want col=%0d fetch=%h",
                     out_col, fetch_vals, hold_c + 1, exp_fetch);
        end
    endtask

    task automatic test_row_start();
        for (int b = 0; b < 17; b++) begin
            rand_vals(); send_beat(b == 0, 1'b0, 1'b0);
        end
        rand_vals(); send_beat(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (out_col !== '0 || out_last !== 1'b0 || (fetch_vals & exp_mask) !== (exp_fetch & exp_mask)) begin
            n_bad++;
            $display("FAIL row_start_early: col=%0d last=%b fetch=%h want 0 0 %h",
                     out_col, out_last, fetch_vals, exp_fetch);
        end
        for (int k = 1; k < 32; k++) begin
            rand_vals(); send_beat(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (out_last !== (k == 31) || out_col !== CW'(k) || (fetch_vals & exp_mask) !== (exp_fetch & exp_mask)) begin
                n_bad++;
                $display("FAIL row_start_follow k=%0d: last=%b col=%0d fetch=%h want %b %0d %h",
                         k, out_last, out_col, fetch_vals, k == 31, k, exp_fetch);
            end
        end
    endtask

    task automatic test_frame_restart();
        for (int b = 0; b < 128; b++) begin
            rand_vals(); store_vals[0][0] = BIN'(b + 1); send_beat(b == 0, 1'b0, 1'b0);
        end
        for (int b = 0; b < 3; b++) begin
            rand_vals(); send_beat(b == 0, 1'b0, 1'b0);
            n_cmp++;
            if (fetch_vals !== '0 || out_col !== CW'(b)) begin
                n_bad++;
                $display("FAIL frame_restart b=%0d: fetch=%h col=%0d want 0 col %0d", b, fetch_vals, out_col, b);
            end
        end
    endtask

    task automatic test_accum();
        logic [BIN-1:0] want;
`ifdef PRB_ACCUM_EN
        want = 16'hFFFF;
`else
        want = 16'h0020;
`endif
        for (int b = 0; b < 65; b++) begin
            rand_vals();
            if (b == 2)  for (int c = 0; c < int'(CH); c++) store_vals[c][0] = 16'hFFF0;
            if (b == 34) for (int c = 0; c < int'(CH); c++) store_vals[c][0] = 16'h0020;
            send_beat(b == 0, 1'b0, b == 34);
            if (b == 32 || b == 64) begin
                for (int c = 0; c < int'(CH); c++) begin
                    n_cmp++;
                    if (fetch_vals[c][1] !== ((b == 32) ? 16'hFFF0 : want)) begin
                        n_bad++;
                        $display("FAIL accum b=%0d ch=%0d: got %h want %h", b, c, fetch_vals[c][1],
                                 (b == 32) ? 16'hFFF0 : want);
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        for (int b = 0; b < 5; b++) begin
            rand_vals(); send_beat(1'b0, 1'b0, 1'b0);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || fetch_vals !== '0 || out_col !== '0) begin
            n_bad++;
            $display("FAIL async_reset: valid=%b fetch=%h col=%0d want 0", out_valid, fetch_vals, out_col);
        end
        m_col = 0; m_rows = 0; exp_ov = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        rand_vals(); send_beat(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (fetch_vals !== '0 || out_col !== '0 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_beat: fetch=%h col=%0d valid=%b want 0 0 1", fetch_vals, out_col, out_valid);
        end
    endtask

    task automatic test_random();
        bit rdy;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        exp_ov = 1'b0;
        for (int n = 0; n < 600; n++) begin
            in_valid    = ($urandom % 4) != 0;
            out_ready   = ($urandom % 3) != 0;
            frame_start = ($urandom % 64) == 0;
            row_start   = ($urandom % 16) == 0;
            accum       = ($urandom % 2) == 1;
            rand_vals();
            #1;
            rdy = !exp_ov || out_ready;
            n_cmp++;
            if (in_ready !== rdy) begin
                n_bad++; $display("FAIL rand_ready n=%0d: got %b want %b", n, in_ready, rdy);
            end
            if (in_valid && rdy) model_step();
            else if (out_ready) exp_ov = 1'b0;
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== exp_ov || (exp_ov && ((fetch_vals & exp_mask) !== (exp_fetch & exp_mask)
                || out_col !== CW'(exp_col) || out_last !== exp_last))) begin
                n_bad++;
                $display("FAIL rand_out n=%0d: valid=%b fetch=%h col=%0d last=%b want %b %h %0d %b",
                         n, out_valid, fetch_vals, out_col, out_last, exp_ov, exp_fetch, exp_col, exp_last);
            end
        end
        in_valid = 1'b0; frame_start = 1'b0; row_start = 1'b0; accum = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        test_reset();
        test_fill();
        test_stall();
        test_row_start();
        test_frame_restart();
        test_accum();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
